// File: rtl/scan_link_pkg.sv
// Shared types and constants for the scanner output-link arbiter.
// Contents: link FSM state enum, frame field widths, scanner command codes,
// and a helper returning the frame length in bits for a given frame type.
package scan_link_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StGap
  } link_state_e;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned DATA_BITS = 8;

  localparam logic [7:0] CMD_READY_TO_TRANSFER = 8'd2;
  localparam logic [7:0] CMD_START_SCANNING    = 8'd3;
  localparam logic [7:0] CMD_BUFFER_FULL       = 8'd4;
  localparam logic [7:0] CMD_DATA_FOLLOWS      = 8'd7;

  // Number of bits shifted for a frame: command only, or command plus data.
  function automatic logic [4:0] frame_bits(input logic with_data);
    return with_data ? 5'(CMD_BITS + DATA_BITS) : 5'(CMD_BITS);
  endfunction

endpackage

// File: rtl/scan_link_serializer.sv
// Frame serializer for the scanner output link.
// Holds the 16-bit shift register, the bit-period divider, the 5-bit bit
// counter and the registered ser_clk/ser_data outputs.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start_i      one-cycle load strobe; word_i/nbits_i are captured
//   word_i       {data, cmd}, shifted out LSB-first
//   nbits_i      number of bits to send (8 or 16)
//   done_o       high in the last cycle of the last bit period
//   ser_clk_o    high in the second half of each bit period
//   ser_data_o   current bit, stable for the whole period; 0 when idle
module scan_link_serializer #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] word_i,
  input  logic [4:0]  nbits_i,
  output logic        done_o,
  output logic        ser_clk_o,
  output logic        ser_data_o
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

  logic [15:0]     shift_q, shift_d;
  logic [DivW-1:0] div_q, div_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [4:0]      nbits_q, nbits_d;
  logic            active_q, active_d;
  logic            ser_clk_q, ser_clk_d;
  logic            ser_data_q, ser_data_d;
  logic            bit_end;
  logic [DivW-1:0] div_inc;

  assign bit_end = active_q && (div_q == DivLast);
  assign done_o  = bit_end && ((bit_cnt_q + 5'd1) == nbits_q);
  assign div_inc = div_q + DivW'(1);

  always_comb begin
    shift_d    = shift_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    active_d   = active_q;
    ser_clk_d  = ser_clk_q;
    ser_data_d = ser_data_q;
    if (start_i) begin
      shift_d    = word_i;
      nbits_d    = nbits_i;
      bit_cnt_d  = '0;
      div_d      = '0;
      active_d   = 1'b1;
      ser_clk_d  = 1'b0;
      ser_data_d = word_i[0];
    end else if (active_q) begin
      if (bit_end) begin
        div_d     = '0;
        ser_clk_d = 1'b0;
        if (done_o) begin
          active_d   = 1'b0;
          bit_cnt_d  = '0;
          ser_data_d = 1'b0;
        end else begin
          shift_d    = {1'b0, shift_q[15:1]};
          bit_cnt_d  = bit_cnt_q + 5'd1;
          ser_data_d = shift_q[1];
        end
      end else begin
        div_d     = div_inc;
        // Registered, so ser_clk follows the divider value it is entering.
        ser_clk_d = (div_inc >= DivHalf);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      active_q   <= 1'b0;
      ser_clk_q  <= 1'b0;
      ser_data_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      active_q   <= active_d;
      ser_clk_q  <= ser_clk_d;
      ser_data_q <= ser_data_d;
    end
  end

  assign ser_clk_o  = ser_clk_q;
  assign ser_data_o = ser_data_q;

endmodule

// File: rtl/scan_link_arbiter.sv
// Round-robin arbiter sharing one serial output link between two scanners.
// A winning scanner's command byte (and data byte, if is_data) is captured
// and shifted out LSB-first, followed by an idle gap.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   req        per-scanner level request, held until ack
//   is_data    per-scanner frame type (1 = cmd + data, 0 = cmd only)
//   cmd, data  byte i of each bus belongs to scanner i
//   grant      one-hot, from LOAD through the last shift cycle
//   ack        one-cycle pulse in the first gap cycle
//   busy       high whenever the FSM is not idle
//   ser_clk    serial bit clock
//   ser_data   serial data
// GAP_BITS must be at least 1: the gap hosts the ack pulse.
module scan_link_arbiter
  import scan_link_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  is_data,
  input  logic [15:0] cmd,
  input  logic [15:0] data,
  output logic [1:0]  grant,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        ser_clk,
  output logic        ser_data
);

  localparam int unsigned GapCycles = GAP_BITS * CLK_DIV;
  localparam int unsigned GapW      = $clog2(GapCycles + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

  link_state_e     state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            last_q, last_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic            win_idx;
  logic            sel;
  logic [15:0]     load_word;
  logic [4:0]      load_nbits;
  logic            ser_start;
  logic            ser_done;

  // Scanner 1 wins if it is the only requester, or on contention when
  // scanner 0 was served last.
  assign win_idx = req[1] & (~req[0] | ~last_q);

  // During LOAD the registered grant selects which scanner's inputs to capture.
  assign sel        = grant_q[1];
  assign load_word  = sel ? {data[15:8], cmd[15:8]} : {data[7:0], cmd[7:0]};
  assign load_nbits = frame_bits(is_data[sel]);
  assign ser_start  = (state_q == StLoad);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = 2'b00;
    last_d    = last_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          state_d = StLoad;
          grant_d = win_idx ? 2'b10 : 2'b01;
          last_d  = win_idx;
        end
      end
      StLoad: begin
        state_d = StShift;
      end
      StShift: begin
        if (ser_done) begin
          state_d   = StGap;
          ack_d     = grant_q;
          grant_d   = 2'b00;
          gap_cnt_d = '0;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d   = StIdle;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      ack_q     <= 2'b00;
      busy_q    <= 1'b0;
      last_q    <= 1'b1;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  scan_link_serializer #(
    .CLK_DIV(CLK_DIV)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (ser_start),
    .word_i    (load_word),
    .nbits_i   (load_nbits),
    .done_o    (ser_done),
    .ser_clk_o (ser_clk),
    .ser_data_o(ser_data)
  );

  assign grant = grant_q;
  assign ack   = ack_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_scan_link_arbiter.sv
module tb_scan_link_arbiter;

  localparam int D = 8;
  localparam int G = 1;
  localparam int MAXC = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  is_data;
  logic [15:0] cmd;
  logic [15:0] data;
  logic [1:0]  grant;
  logic [1:0]  ack;
  logic        busy;
  logic        ser_clk;
  logic        ser_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed / expected per-cycle outputs: {grant, ack, busy, ser_clk, ser_data}.
  logic [6:0] obs  [0:MAXC-1];
  logic [6:0] expv [0:MAXC-1];
  bit         auto_drop;
  int         model_last;

  scan_link_arbiter #(
    .CLK_DIV (D),
    .GAP_BITS(G)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .is_data (is_data),
    .cmd     (cmd),
    .data    (data),
    .grant   (grant),
    .ack     (ack),
    .busy    (busy),
    .ser_clk (ser_clk),
    .ser_data(ser_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) expv[i] = '0;
  endtask

  // One frame whose LOAD cycle is at index s: LOAD, nbits bit periods, gap.
  task automatic model_frame(input int s, input int who, input logic [7:0] c,
                             input logic [7:0] dt, input bit with_data, output int len);
    int nb;
    int active;
    int b;
    int ph;
    logic [1:0] oh;
    logic bitv;
    nb     = with_data ? 16 : 8;
    oh     = (who == 1) ? 2'b10 : 2'b01;
    active = nb * D;
    len    = 1 + active + G * D;
    expv[s] = {oh, 2'b00, 1'b1, 1'b0, 1'b0};
    for (int n = 0; n < active; n++) begin
      b    = n / D;
      ph   = n % D;
      bitv = (b < 8) ? c[b] : dt[b-8];
      expv[s+1+n] = {oh, 2'b00, 1'b1, (ph >= D / 2), bitv};
    end
    expv[s+1+active] = {2'b00, oh, 1'b1, 1'b0, 1'b0};
    for (int n = 1; n < G * D; n++) expv[s+1+active+n] = 7'b0000100;
  endtask

  // Acts as the scanner side: records outputs, optionally drops req on ack.
  task automatic capture(input int from, input int n);
    for (int i = from; i < from + n; i++) begin
      @(posedge clk);
      #1;
      obs[i] = {grant, ack, busy, ser_clk, ser_data};
      if (auto_drop) req = req & ~ack;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int l0;
    int l1;
    int total;
    logic [7:0] c0, c1, d0, d1;
    c0 = 8'($urandom); c1 = 8'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
    cmd = {c1, c0}; data = {d1, d0}; is_data = 2'b00;
    rst = 1'b1; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({grant, ack, busy, ser_clk, ser_data} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: got %b want 0000000", k,
                 {grant, ack, busy, ser_clk, ser_data});
      end
    end
    rst = 1'b0;
    auto_drop = 1'b1;
    clear_model();
    model_frame(0, 0, c0, d0, 1'b0, l0);
    model_frame(l0 + 1, 1, c1, d1, 1'b0, l1);
    model_last = 1;
    total = l0 + 1 + l1 + 3;
    capture(0, total);
    for (int i = 0; i < total; i++) begin
      n_checks++;
      if (obs[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL reset_first_grant cyc %0d: got %b want %b", i, obs[i], expv[i]);
      end
    end
  endtask

  task automatic test_cmd_frame();
    int len;
    int total;
    int pulses;
    int highs;
    int ack_at;
    logic [7:0] c1;
    c1 = 8'($urandom);
    cmd = {c1, 8'h03}; data = 16'($urandom); is_data = {1'($urandom), 1'b0};
    auto_drop = 1'b1; req = 2'b01;
    clear_model();
    model_frame(0, 0, 8'h03, data[7:0], 1'b0, len);
    model_last = 0;
    total = len + 4;
    capture(0, total);
    for (int i = 0; i < total; i++) begin
      n_checks++;
      if (obs[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL cmd_frame cyc %0d: got %b want %b", i, obs[i], expv[i]);
      end
    end
    pulses = 0; highs = 0; ack_at = -1;
    for (int i = 1; i < total; i++) begin
      if (obs[i][1] === 1'b1 && obs[i-1][1] === 1'b0) pulses++;
      if (obs[i][1] === 1'b1) highs++;
      if (ack_at < 0 && obs[i][4:3] !== 2'b00) ack_at = i;
    end
    n_checks++;
    if (pulses != 8) begin
      n_fail++;
      $display("FAIL cmd_frame_pulses: got %0d want 8", pulses);
    end
    n_checks++;
    if (highs != 32) begin
      n_fail++;
      $display("FAIL cmd_frame_clk_high: got %0d want 32", highs);
    end
    // obs[0] is cycle t+1, so ack at t+66 is index 65.
    n_checks++;
    if (ack_at != 65) begin
      n_fail++;
      $display("FAIL cmd_frame_ack_time: got %0d want 65", ack_at);
    end
  endtask

  task automatic test_data_frame();
    int len;
    int total;
    int ack_at;
    cmd = {8'h07, 8'($urandom)}; data = {8'h09, 8'($urandom)}; is_data = {1'b1, 1'($urandom)};
    auto_drop = 1'b1; req = 2'b10;
    clear_model();
    model_frame(0, 1, 8'h07, 8'h09, 1'b1, len);
    model_last = 1;
    total = len + 4;
    capture(0, total);
    ack_at = -1;
    for (int i = 0; i < total; i++) begin
      n_checks++;
      if (obs[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL data_frame cyc %0d: got %b want %b", i, obs[i], expv[i]);
      end
      if (ack_at < 0 && obs[i][4:3] !== 2'b00) ack_at = i;
    end
    n_checks++;
    if (ack_at != 129) begin
      n_fail++;
      $display("FAIL data_frame_ack_time: got %0d want 129", ack_at);
    end
  endtask

  task automatic test_random_frames();
    int len;
    int total;
    int who;
    bit wd;
    for (int it = 0; it < 6; it++) begin
      who = int'($urandom_range(1, 0));
      cmd = 16'($urandom); data = 16'($urandom); is_data = 2'($urandom);
      wd = is_data[who];
      auto_drop = 1'b1;
      req = (who == 1) ? 2'b10 : 2'b01;
      clear_model();
      model_frame(0, who, cmd[8*who +: 8], data[8*who +: 8], wd, len);
      model_last = who;
      total = len + 3;
      capture(0, total);
      for (int i = 0; i < total; i++) begin
        n_checks++;
        if (obs[i] !== expv[i]) begin
          n_fail++;
          $display("FAIL random_frame it %0d cyc %0d: got %b want %b", it, i, obs[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_contention();
    int s;
    int len;
    int who;
    int last_start;
    int last_len;
    int total;
    logic [7:0] c0, c1, d0, d1;
    bit w0, w1;
    c0 = 8'($urandom); c1 = 8'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
    w0 = 1'($urandom); w1 = 1'($urandom);
    cmd = {c1, c0}; data = {d1, d0}; is_data = {w1, w0};
    clear_model();
    s = 0; last_start = 0; last_len = 0;
    who = (model_last == 1) ? 0 : 1;
    for (int k = 0; k < 4; k++) begin
      model_frame(s, who, (who == 1) ? c1 : c0, (who == 1) ? d1 : d0,
                  (who == 1) ? w1 : w0, len);
      last_start = s; last_len = len; model_last = who;
      // Next LOAD follows the gap plus a single IDLE cycle.
      s = s + len + 1;
      who = 1 - who;
    end
    total = last_start + last_len + 4;
    auto_drop = 1'b0; req = 2'b11;
    capture(0, last_start + 5);
    req = 2'b00;
    capture(last_start + 5, total - (last_start + 5));
    for (int i = 0; i < total; i++) begin
      n_checks++;
      if (obs[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL contention cyc %0d: got %b want %b", i, obs[i], expv[i]);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    int len;
    int total;
    logic [7:0] c0, d0;
    bit w0;
    c0 = 8'($urandom); d0 = 8'($urandom); w0 = 1'($urandom);
    cmd = {8'($urandom), c0}; data = {8'($urandom), d0}; is_data = {1'($urandom), w0};
    auto_drop = 1'b1; req = 2'b01;
    clear_model();
    model_frame(0, 0, c0, d0, w0, len);
    model_last = 0;
    total = len + 4;
    capture(0, 20);
    cmd[7:0] = ~c0; data[7:0] = ~d0; is_data[0] = ~w0; req[0] = 1'b0;
    capture(20, total - 20);
    for (int i = 0; i < total; i++) begin
      n_checks++;
      if (obs[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL mid_frame_change cyc %0d: got %b want %b", i, obs[i], expv[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int len;
    int total;
    int who;
    int cut;
    logic [7:0] c;
    who = int'($urandom_range(1, 0));
    c = 8'($urandom) | 8'h20;
    cmd = {c, c}; data = 16'($urandom); is_data = 2'b00;
    auto_drop = 1'b1;
    req = (who == 1) ? 2'b10 : 2'b01;
    clear_model();
    model_frame(0, who, c, data[8*who +: 8], 1'b0, len);
    // Stop in the high half of bit 5, where ser_clk and ser_data are both 1.
    cut = 1 + 5 * D + D / 2 + 2;
    capture(0, cut);
    for (int i = 0; i < cut; i++) begin
      n_checks++;
      if (obs[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL pre_abort cyc %0d: got %b want %b", i, obs[i], expv[i]);
      end
    end
    rst = 1'b1; req = 2'b00;
    @(posedge clk);
    #1;
    n_checks++;
    if ({grant, ack, busy, ser_clk, ser_data} !== 7'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b want 0000000", {grant, ack, busy, ser_clk, ser_data});
    end
    rst = 1'b0;
    model_last = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({grant, ack, busy, ser_clk, ser_data} !== 7'b0) begin
        n_fail++;
        $display("FAIL abort_no_ack cyc %0d: got %b want 0000000", k,
                 {grant, ack, busy, ser_clk, ser_data});
      end
    end
    who = int'($urandom_range(1, 0));
    cmd = 16'($urandom); data = 16'($urandom); is_data = 2'($urandom);
    req = (who == 1) ? 2'b10 : 2'b01;
    clear_model();
    model_frame(0, who, cmd[8*who +: 8], data[8*who +: 8], is_data[who], len);
    model_last = who;
    total = len + 3;
    capture(0, total);
    for (int i = 0; i < total; i++) begin
      n_checks++;
      if (obs[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL after_abort cyc %0d: got %b want %b", i, obs[i], expv[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; is_data = 2'b00; cmd = '0; data = '0;
    auto_drop = 1'b0; model_last = 1;
    test_reset();
    test_cmd_frame();
    test_data_frame();
    test_random_frames();
    test_contention();
    test_mid_frame_change();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_link_arbiter.md
# scan_link_arbiter

Shares the single serial output link (ser_clk/ser_data) between the two scanner units. Grants the link round-robin to whichever scanner raises a transfer request, captures its command byte and optional data byte, and shifts the frame out LSB-first at a divided bit rate. Sits between the scanner pair and the off-chip output driver, replacing per-scanner direct pin driving.

## Interface

- CLK_DIV, 8: system clocks per serial bit; even, ≥ 2.
- GAP_BITS, 1: idle bit periods inserted after every frame.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-scanner transfer request (bit i = scanner i); level, held until ack[i].
- is_data  in  2  per-scanner frame type: 1 = command + data (16 bits), 0 = command only (8 bits).
- cmd  in  16  cmd[8i+7:8i] = command byte of scanner i.
- data  in  16  data[8i+7:8i] = data byte of scanner i.
- grant  out  2  one-hot; high from LOAD through the last SHIFT cycle for the served scanner.
- ack  out  2  one-cycle pulse when scanner i's frame has fully shifted out.
- busy  out  1  high in any state other than IDLE.
- ser_clk  out  1  serial bit clock; high in the second half of each bit period.
- ser_data  out  1  serial data; stable for the whole bit period.

## Operation

- States: IDLE, LOAD, SHIFT, GAP.
- IDLE: if req != 0, select winner; go to LOAD. Otherwise stay.
- Arbitration: round-robin. last_served pointer. On contention, the scanner not served last wins. A single requester always wins. Reset sets last_served = 1, so scanner 0 wins the first contention.
- LOAD (1 cycle): shift_reg[15:0] = {data_i, cmd_i}; nbits = is_data[i] ? 16 : 8; grant[i] = 1; last_served = i.
- SHIFT: ser_data = shift_reg[0] for CLK_DIV cycles. Then shift right by one and increment the bit counter (5 bits). Leave when counter == nbits.
- GAP: ser_data = 0 and ser_clk = 0 for GAP_BITS*CLK_DIV cycles. ack[i] pulses in the first GAP cycle; grant drops in that same cycle. Then go to IDLE.
- Inputs are sampled only in IDLE and LOAD. Changes to cmd, data or is_data during SHIFT or GAP are ignored.
- req[i] dropping mid-frame does not abort the frame; ack[i] is still issued.
- A req[i] still high when IDLE is re-entered is a new request.
- Reset values: grant = 0, ack = 0, busy = 0, ser_clk = 0, ser_data = 0, state = IDLE, counters = 0.
- rst mid-frame aborts immediately: no ack, and the line returns to 0 on the next cycle.

## Timing

- req[i] high at edge t in IDLE:
  - LOAD and grant[i] during cycle t+1.
  - First bit on ser_data at cycle t+2.
  - ser_clk high during cycles t+2+CLK_DIV/2 … t+2+CLK_DIV-1 of each bit period.
- Bit b occupies cycles t+2+b*CLK_DIV … t+2+(b+1)*CLK_DIV-1.
- ack[i] at cycle t+2+nbits*CLK_DIV.
- IDLE is re-entered GAP_BITS*CLK_DIV cycles after ack; the next request can be granted on the cycle after that.
- Frame span with CLK_DIV = 8, GAP_BITS = 1:
  - 8-bit frame: 1 + 64 + 8 = 73 cycles from LOAD to return to IDLE.
  - 16-bit frame: 137 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Package scan_link_pkg holds:
  - state enum {IDLE, LOAD, SHIFT, GAP};
  - CMD_BITS = 8, DATA_BITS = 8;
  - command codes: CMD_READY_TO_TRANSFER = 8'd2, CMD_START_SCANNING = 8'd3, CMD_BUFFER_FULL = 8'd4, CMD_DATA_FOLLOWS = 8'd7.
- One sub-module: scan_link_serializer, containing the shift register, bit-period divider, bit counter and ser_clk/ser_data registers. It has a load/start input and a done output.
- The top level holds the FSM, the round-robin pointer, grant and ack.

## Test plan

- Reset with req = 2'b11 held → all outputs 0 during reset. First grant after release is 2'b01.
- Command-only frame: req = 2'b01, is_data = 0, cmd0 = 8'h03, CLK_DIV = 8 → ser_data bits 1,1,0,0,0,0,0,0. Eight ser_clk pulses, each 4 cycles high. ack = 2'b01 exactly 66 cycles after req was sampled.
- Data frame: req = 2'b10, is_data = 2'b10, cmd1 = 8'h07, data1 = 8'h09 → 16 bits LSB-first, 0x07 then 0x09. 16 ser_clk pulses. ack[1] at cycle t+130.
- Contention: req = 2'b11 held continuously → frames alternate scanner 0, 1, 0, 1. Each pair of consecutive grants is separated by exactly one GAP plus one IDLE cycle.
- Mid-frame input change: cmd0 altered and req[0] dropped during SHIFT → the original byte is shifted out unchanged and ack[0] is still issued.
- Reset asserted at bit 5 of a frame → next cycle: ser_clk = 0, ser_data = 0, busy = 0, no ack pulse. A new request afterwards is served normally.
